// File: rtl/io_pkg.sv
// Shared types and defaults for the multi-channel IO block.
package io_pkg;

  // Handshake FSM for input (wait-for-operator) instructions
  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    DONE,
    WAIT_RELEASE
  } io_state_t;

  localparam int unsigned IO_DATA_W_DEF          = 32;
  localparam int unsigned IO_IN_W_DEF            = 13;
  localparam int unsigned IO_N_OUT_DEF           = 4;
  localparam int unsigned IO_SYNC_STAGES_DEF     = 2;
  localparam int unsigned IO_DEBOUNCE_CYCLES_DEF = 16;

  // Channel-select width for a power-of-two channel count
  function automatic int unsigned ch_w(input int unsigned n_out);
    return $clog2(n_out);
  endfunction

endpackage

// File: rtl/io_botao_sync.sv
// Single-bit synchroniser with optional debounce filter for a push button.
// Optional feature: IO_DEBOUNCE_EN enables the debounce filter.
module io_botao_sync
  import io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = IO_SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic botao,
  output logic filtrado
);

`ifdef IO_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  // Zero stable-sample requirement selects the direct path below
  localparam int unsigned DB_N = DB_EN ? DEBOUNCE_CYCLES : 0;

  logic [SYNC_STAGES-1:0] cadeia;
  logic                   sincronizado;

  // Synchroniser chain, resets to the released level
  always_ff @(posedge Clock) begin
    if (Reset) cadeia <= '1;
    else       cadeia <= {cadeia[SYNC_STAGES-2:0], botao};
  end

  assign sincronizado = cadeia[SYNC_STAGES-1];

  generate
    if (DB_N > 0) begin : g_debounce
      localparam int unsigned CNT_W = $clog2(DB_N + 1);
      logic [CNT_W-1:0] cnt;
      logic             estavel;

      // Accept a new level only after DB_N consecutive differing samples
      always_ff @(posedge Clock) begin
        if (Reset) begin
          estavel <= 1'b1;
          cnt     <= '0;
        end else if (sincronizado == estavel) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DB_N - 1)) begin
          estavel <= sincronizado;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign filtrado = estavel;
    end else begin : g_direct
      assign filtrado = sincronizado;
    end
  endgenerate

endmodule

// File: rtl/io_multicanal.sv
// Multi-channel IO block: N addressable output registers plus a switch port
// captured through a push-button handshake that stalls the processor.
// Optional feature: IO_DEBOUNCE_EN (debounce on Set, see io_botao_sync).
module io_multicanal
  import io_pkg::*;
#(
  parameter int unsigned DATA_W          = IO_DATA_W_DEF,
  parameter int unsigned IN_W            = IO_IN_W_DEF,
  parameter int unsigned N_OUT           = IO_N_OUT_DEF,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int unsigned SYNC_STAGES     = IO_SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES_DEF
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    OpIO,
  input  logic                    HaltIAS,
  input  logic [31:0]             Endereco,
  input  logic [DATA_W-1:0]       DadosSaida,
  input  logic [IN_W-1:0]         Switches,
  input  logic                    Set,
  output logic [DATA_W-1:0]       DataIO,
  output logic [N_OUT*DATA_W-1:0] Output,
  output logic                    Halt
);

  localparam int unsigned CH_W = ch_w(N_OUT);

  io_state_t       st, nxt;
  logic            req, wr_hit;
  logic            set_filt, set_prev, press;
  logic            halt_c, capture;
  logic [IN_W-1:0] sw_sync [SYNC_STAGES];

  assign req    = OpIO & HaltIAS;
  assign wr_hit = OpIO & ~HaltIAS & (Endereco[31:CH_W] == BASE_ADDR[31:CH_W]);

  // Output channel registers, addressed by the low address bits
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Output <= '0;
    end else if (wr_hit) begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (Endereco[CH_W-1:0] == CH_W'(k))
          Output[k*DATA_W +: DATA_W] <= DadosSaida;
      end
    end
  end

  // Switch synchroniser, same depth as Set so both arrive together
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
    end else begin
      sw_sync[0] <= Switches;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
    end
  end

  io_botao_sync #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_set (
    .Clock    (Clock),
    .Reset    (Reset),
    .botao    (Set),
    .filtrado (set_filt)
  );

  // Previous filtered Set level for falling-edge (press) detection
  always_ff @(posedge Clock) begin
    if (Reset) set_prev <= 1'b1;
    else       set_prev <= set_filt;
  end

  assign press = set_prev & ~set_filt;

  // FSM state register and captured switch value
  always_ff @(posedge Clock) begin
    if (Reset) begin
      st     <= IDLE;
      DataIO <= '0;
    end else begin
      st <= nxt;
      if (capture) DataIO <= DATA_W'(sw_sync[SYNC_STAGES-1]);
    end
  end

  // Next-state and stall logic; a flush in WAIT_PRESS wins over a press
  always_comb begin
    nxt     = st;
    halt_c  = 1'b0;
    capture = 1'b0;
    case (st)
      IDLE: begin
        halt_c = req;
        if (req) nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        halt_c = 1'b1;
        if (!req) begin
          nxt = IDLE;
        end else if (press) begin
          capture = 1'b1;
          nxt     = DONE;
        end
      end
      DONE: begin
        nxt = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        halt_c = req;
        if (set_filt) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign Halt = halt_c & ~Reset;

endmodule

// File: tb/tb_io_multicanal.sv
// Self-checking bench for io_multicanal: table-driven writes, randomized
// traffic against a behavioural model, and hand-written handshake sequences.
module tb_io_multicanal;

  localparam int DATA_W = 32;
  localparam int IN_W   = 13;
  localparam int N_OUT  = 4;
  localparam int SYNC   = 2;
  localparam int DEB    = 16;
  localparam logic [31:0] BASE = 32'h40;
`ifdef IO_DEBOUNCE_EN
  localparam int DB_LAT = DEB;
`else
  localparam int DB_LAT = 0;
`endif
  localparam int LAT = SYNC + 1 + DB_LAT;

  logic                    Clock = 1'b0;
  logic                    Reset = 1'b1;
  logic                    OpIO = 1'b0;
  logic                    HaltIAS = 1'b0;
  logic [31:0]             Endereco = '0;
  logic [DATA_W-1:0]       DadosSaida = '0;
  logic [IN_W-1:0]         Switches = '0;
  logic                    Set = 1'b1;
  logic [DATA_W-1:0]       DataIO;
  logic [N_OUT*DATA_W-1:0] Output;
  logic                    Halt;

  io_multicanal #(
    .DATA_W          (DATA_W),
    .IN_W            (IN_W),
    .N_OUT           (N_OUT),
    .BASE_ADDR       (BASE),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .OpIO       (OpIO),
    .HaltIAS    (HaltIAS),
    .Endereco   (Endereco),
    .DadosSaida (DadosSaida),
    .Switches   (Switches),
    .Set        (Set),
    .DataIO     (DataIO),
    .Output     (Output),
    .Halt       (Halt)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    OpIO = 1'b0; HaltIAS = 1'b0; Endereco = '0; DadosSaida = '0;
  endtask

  task automatic request(input logic [IN_W-1:0] sw);
    Switches = sw; OpIO = 1'b1; HaltIAS = 1'b1; Endereco = BASE;
  endtask

  // Advance until Halt drops (capture); returns cycles since the call, 0 on timeout
  task automatic wait_capture(output int lat);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge Clock); #1;
      if (!Halt) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic                      op;
    logic                      hi;
    logic [31:0]               addr;
    logic [31:0]               data;
    logic                      halt;
    logic [N_OUT-1:0][31:0]    exp;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] m_ch [N_OUT];
  logic [N_OUT*DATA_W-1:0] m_out;

  initial begin
    int  lat;
    bit  req_prev;
    bit  dropped;
    logic op, hi;

    // exp packed as {ch3, ch2, ch1, ch0}
    tbl[0] = '{1'b1, 1'b0, 32'h42,       32'hDEADBEEF, 1'b0, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}};
    tbl[1] = '{1'b1, 1'b0, 32'h44,       32'h11111111, 1'b0, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}};
    tbl[2] = '{1'b1, 1'b0, 32'h40,       32'hA5A5A5A5, 1'b0, {32'h0, 32'hDEADBEEF, 32'h0, 32'hA5A5A5A5}};
    tbl[3] = '{1'b1, 1'b0, 32'h43,       32'h12345678, 1'b0, {32'h12345678, 32'hDEADBEEF, 32'h0, 32'hA5A5A5A5}};
    tbl[4] = '{1'b1, 1'b0, 32'h3F,       32'hFFFFFFFF, 1'b0, {32'h12345678, 32'hDEADBEEF, 32'h0, 32'hA5A5A5A5}};
    tbl[5] = '{1'b1, 1'b1, 32'h41,       32'h77777777, 1'b1, {32'h12345678, 32'hDEADBEEF, 32'h0, 32'hA5A5A5A5}};
    tbl[6] = '{1'b0, 1'b0, 32'h41,       32'h66666666, 1'b0, {32'h12345678, 32'hDEADBEEF, 32'h0, 32'hA5A5A5A5}};
    tbl[7] = '{1'b1, 1'b0, 32'h41,       32'h0BADF00D, 1'b0, {32'h12345678, 32'hDEADBEEF, 32'h0BADF00D, 32'hA5A5A5A5}};
    tbl[8] = '{1'b1, 1'b0, 32'h10000042, 32'hCAFEBABE, 1'b0, {32'h12345678, 32'hDEADBEEF, 32'h0BADF00D, 32'hA5A5A5A5}};
    tbl[9] = '{1'b1, 1'b0, 32'h42,       32'h00000000, 1'b0, {32'h12345678, 32'h0, 32'h0BADF00D, 32'hA5A5A5A5}};

    // Reset with a request pending: Halt must stay low while Reset is high
    OpIO = 1'b1; HaltIAS = 1'b1;
    repeat (3) @(negedge Clock);
    #1 check("halt_during_reset", Halt, 1'b0);
    check("output_reset", Output, '0);
    check("dataio_reset", DataIO, '0);
    Reset = 1'b0;
    bus_idle();
    repeat (2) @(negedge Clock);

    // Table-driven writes
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      OpIO = tbl[i].op; HaltIAS = tbl[i].hi; Endereco = tbl[i].addr; DadosSaida = tbl[i].data;
      #1 check($sformatf("tbl%0d_halt", i), Halt, tbl[i].halt);
      @(negedge Clock);
      bus_idle();
      #1;
      for (int k = 0; k < N_OUT; k++)
        check($sformatf("tbl%0d_ch%0d", i, k), Output[k*DATA_W +: DATA_W], tbl[i].exp[k]);
    end

    // Randomized traffic with Set released: Halt = req now or req last cycle
    for (int k = 0; k < N_OUT; k++) m_ch[k] = tbl[9].exp[k];
    req_prev = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge Clock);
      op = 1'($urandom_range(0, 1));
      hi = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0, 1:    Endereco = BASE + 32'($urandom_range(0, N_OUT - 1));
        2:       Endereco = BASE + N_OUT + 32'($urandom_range(0, 7));
        default: Endereco = $urandom();
      endcase
      OpIO = op; HaltIAS = hi; DadosSaida = $urandom();
      #1;
      for (int k = 0; k < N_OUT; k++) m_out[k*DATA_W +: DATA_W] = m_ch[k];
      check("rnd_halt", Halt, (op & hi) | req_prev);
      check("rnd_output", Output, m_out);
      check("rnd_dataio", DataIO, '0);
      if (op && !hi && Endereco >= BASE && Endereco < BASE + N_OUT)
        m_ch[Endereco - BASE] = DadosSaida;
      req_prev = op & hi;
    end
    @(negedge Clock);
    bus_idle();
    repeat (3) @(negedge Clock);

    // Single input instruction, press after 10 cycles
    request(13'h1ABC);
    #1 check("req1_halt_same_cycle", Halt, 1'b1);
    repeat (10) begin
      @(negedge Clock); #1 check("req1_halt_wait", Halt, 1'b1);
    end
    Set = 1'b0;
    wait_capture(lat);
    check("req1_latency", lat, LAT);
    check("req1_dataio", DataIO, 32'h00001ABC);
    @(negedge Clock);
    bus_idle();
    #1 check("req1_after_done", Halt, 1'b0);
    Set = 1'b1;
    repeat (2 * LAT + 4) @(negedge Clock);

    // Button held across two input instructions: one capture only
    request(13'h0F0F);
    #1 check("req2_halt", Halt, 1'b1);
    repeat (3) @(negedge Clock);
    Set = 1'b0;
    wait_capture(lat);
    check("req2_latency", lat, LAT);
    check("req2_dataio", DataIO, 32'h00000F0F);
    @(negedge Clock);
    Switches = 13'h1234;
    #1 check("req3_halt_after_done", Halt, 1'b1);
    dropped = 1'b0;
    repeat (30) begin
      @(negedge Clock); #1;
      if (!Halt || DataIO !== 32'h00000F0F) dropped = 1'b1;
    end
    check("req3_held_no_capture", dropped, 1'b0);
    Set = 1'b1;
    dropped = 1'b0;
    repeat (2 * LAT + 6) begin
      @(negedge Clock); #1;
      if (!Halt) dropped = 1'b1;
    end
    check("req3_release_still_halted", dropped, 1'b0);
    Set = 1'b0;
    wait_capture(lat);
    check("req3_latency", lat, LAT);
    check("req3_dataio", DataIO, 32'h00001234);
    @(negedge Clock);
    bus_idle();
    Set = 1'b1;
    repeat (2 * LAT + 4) @(negedge Clock);

    // Reset during WAIT_PRESS, then a press without a request
    request(13'h0555);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    #1 check("rst_wp_halt", Halt, 1'b0);
    @(negedge Clock);
    #1 check("rst_wp_dataio", DataIO, '0);
    check("rst_wp_output", Output, '0);
    Reset = 1'b0;
    bus_idle();
    #1 check("rst_wp_halt_after", Halt, 1'b0);
    Set = 1'b0;
    repeat (LAT + 5) @(negedge Clock);
    #1 check("idle_press_halt", Halt, 1'b0);
    check("idle_press_dataio", DataIO, '0);
    request(13'h0555);
    dropped = 1'b0;
    repeat (LAT + 3) begin
      @(negedge Clock); #1;
      if (!Halt) dropped = 1'b1;
    end
    check("stale_press_halted", dropped, 1'b0);
    check("stale_press_dataio", DataIO, '0);
    @(negedge Clock);
    bus_idle();
    Set = 1'b1;
    repeat (2 * LAT + 4) @(negedge Clock);

`ifdef IO_DEBOUNCE_EN
    // Short glitch rejected, long press captured
    request(13'h0AAA);
    repeat (3) @(negedge Clock);
    Set = 1'b0;
    repeat (5) @(negedge Clock);
    Set = 1'b1;
    dropped = 1'b0;
    repeat (40) begin
      @(negedge Clock); #1;
      if (!Halt) dropped = 1'b1;
    end
    check("glitch_no_capture", dropped, 1'b0);
    check("glitch_dataio", DataIO, '0);
    Set = 1'b0;
    wait_capture(lat);
    check("db_press_latency", lat, LAT);
    check("db_press_dataio", DataIO, 32'h00000AAA);
    @(negedge Clock);
    bus_idle();
    Set = 1'b1;
    repeat (2 * LAT + 4) @(negedge Clock);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
